cache_prof_reader: RTL and testbench

Memory-mapped readout for the cache profiler counters. It takes the six free-running counters (i$ refill count and latency, d$ read-refill count and latency, d$ write-back count and latency) and captures them atomically into shadow registers on software command. Software then reads the shadow registers as 32-bit words over the core's device bus. The block sits on the device bus next to the other core-local peripherals and is the software-visible end of the profiling path.

---
 rtl/cache_prof_reader.sv | 134 +++++++++++++
 tb/tb_cache_prof_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_prof_reader.sv
`default_nettype none
// cache_prof_reader: atomic snapshot + 32-bit device-bus readout of the six cache profiler counters. Rev 1.0
// Optional macro PROF_CLR_EN adds the CTRL bit1 clear pulse on prof_clr_o.
module cache_prof_reader #(
  parameter int CNT_BITS = 64,
  parameter int XLEN     = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CNT_BITS-1:0] iflush_cnt_i,
  input  logic [CNT_BITS-1:0] iflush_ltc_i,
  input  logic [CNT_BITS-1:0] dflush_rd_cnt_i,
  input  logic [CNT_BITS-1:0] dflush_rd_ltc_i,
  input  logic [CNT_BITS-1:0] dflush_wb_cnt_i,
  input  logic [CNT_BITS-1:0] dflush_wb_ltc_i,
  input  logic                S_DEVICE_strobe_i,
  input  logic [XLEN-1:0]     S_DEVICE_addr_i,
  input  logic                S_DEVICE_rw_i,
  input  logic [XLEN-1:0]     S_DEVICE_data_i,
  output logic                S_DEVICE_ready_o,
  output logic [XLEN-1:0]     S_DEVICE_data_o
`ifdef PROF_CLR_EN
  ,
  output logic                prof_clr_o
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  localparam logic [5:0] c_WORD_CTRL = 6'd0;
  localparam logic [5:0] c_WORD_SEQ  = 6'd1;
  localparam logic [5:0] c_WORD_CNT0 = 6'd2;
  localparam logic [5:0] c_WORD_CNTN = 6'd13;

  logic [0:0]          r_state;
  logic [5:0]          r_word;
  logic                r_rw;
  logic [1:0]          r_wbits;
  logic [XLEN-1:0]     r_snap_seq;
  logic [CNT_BITS-1:0] r_shadow [6];

  logic [CNT_BITS-1:0] w_live [6];
  logic [63:0]         w_ext [6];
  logic [XLEN-1:0]     w_cnt_word [12];
  logic [5:0]          w_k;
  logic [XLEN-1:0]     w_rdata;
  logic                w_ctrl_wr;
  logic                w_snap;

  assign w_live[0] = iflush_cnt_i;
  assign w_live[1] = iflush_ltc_i;
  assign w_live[2] = dflush_rd_cnt_i;
  assign w_live[3] = dflush_rd_ltc_i;
  assign w_live[4] = dflush_wb_cnt_i;
  assign w_live[5] = dflush_wb_ltc_i;

  // Shadows are zero-extended so narrow counters read 0 in the hi word.
  for (genvar gi = 0; gi < 6; gi++) begin : g_word
    assign w_ext[gi]            = 64'(r_shadow[gi]);
    assign w_cnt_word[2*gi]     = w_ext[gi][31:0];
    assign w_cnt_word[2*gi + 1] = w_ext[gi][63:32];
  end

  assign w_ctrl_wr = (r_state == S_RESP) && r_rw && (r_word == c_WORD_CTRL);
  assign w_snap    = w_ctrl_wr && r_wbits[0];
  assign w_k       = r_word - c_WORD_CNT0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_rw       <= 1'b0;
      r_wbits    <= '0;
      r_snap_seq <= '0;
      for (int i = 0; i < 6; i++) r_shadow[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (S_DEVICE_strobe_i) begin
            r_word  <= S_DEVICE_addr_i[7:2];
            r_rw    <= S_DEVICE_rw_i;
            r_wbits <= S_DEVICE_data_i[1:0];
            r_state <= S_RESP;
          end
        end
        default: begin
          // Strobes seen here are dropped; the master keeps one request in flight.
          r_state <= S_IDLE;
          if (w_snap) begin
            for (int i = 0; i < 6; i++) r_shadow[i] <= w_live[i];
            r_snap_seq <= r_snap_seq + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PROF_CLR_EN
  logic r_clr;

  // Clear fires on the snapshot edge, so a combined write snapshots pre-clear values.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_clr <= 1'b0;
    else       r_clr <= w_ctrl_wr && r_wbits[1];
  end

  assign prof_clr_o = r_clr;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, S_DEVICE_addr_i[XLEN-1:8], S_DEVICE_addr_i[1:0],
                         S_DEVICE_data_i[XLEN-1:2], w_k[5:4]};
`else
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, S_DEVICE_addr_i[XLEN-1:8], S_DEVICE_addr_i[1:0],
                         S_DEVICE_data_i[XLEN-1:2], w_k[5:4], r_wbits[1]};
`endif

  always_comb begin
    w_rdata = '0;
    if (!r_rw) begin
      if (r_word == c_WORD_SEQ) begin
        w_rdata = r_snap_seq;
      end else if (r_word >= c_WORD_CNT0 && r_word <= c_WORD_CNTN) begin
        w_rdata = w_cnt_word[w_k[3:0]];
      end
    end
  end

  assign S_DEVICE_ready_o = (r_state == S_RESP);
  assign S_DEVICE_data_o  = S_DEVICE_ready_o ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cache_prof_reader.sv
`default_nettype none
// tb_cache_prof_reader: directed self-checking bench for cache_prof_reader.
module tb_cache_prof_reader;

  logic        clk;
  logic        rst;
  logic [63:0] cnt [6];
  logic        strobe;
  logic [31:0] addr;
  logic        rw;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
`ifdef PROF_CLR_EN
  logic        prof_clr;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] exp64 [6];
  logic [31:0] exp_seq;

  cache_prof_reader #(.CNT_BITS(64), .XLEN(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .iflush_cnt_i     (cnt[0]),
    .iflush_ltc_i     (cnt[1]),
    .dflush_rd_cnt_i  (cnt[2]),
    .dflush_rd_ltc_i  (cnt[3]),
    .dflush_wb_cnt_i  (cnt[4]),
    .dflush_wb_ltc_i  (cnt[5]),
    .S_DEVICE_strobe_i(strobe),
    .S_DEVICE_addr_i  (addr),
    .S_DEVICE_rw_i    (rw),
    .S_DEVICE_data_i  (wdata),
    .S_DEVICE_ready_o (ready),
    .S_DEVICE_data_o  (rdata)
`ifdef PROF_CLR_EN
    ,
    .prof_clr_o       (prof_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns ready/data in the response cycle and the cycle after.
  task automatic bus_xfer(input logic i_rw, input logic [31:0] i_addr, input logic [31:0] i_wd,
                          output logic o_rdy, output logic [31:0] o_data,
                          output logic o_rdy_n, output logic [31:0] o_data_n);
    strobe = 1'b1; rw = i_rw; addr = i_addr; wdata = i_wd;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; wdata = '0;
    o_rdy = ready; o_data = rdata;
    @(negedge clk);
    o_rdy_n = ready; o_data_n = rdata;
  endtask

  task automatic test_reset();
    logic r1, rn; logic [31:0] d1, dn;
    logic [31:0] offs [3];
    offs[0] = 32'h04; offs[1] = 32'h08; offs[2] = 32'h34;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (ready !== 1'b0 || rdata !== 32'h0) $display("FAIL reset_outputs ready=%b data=%h want 0/0", ready, rdata);
    else n_pass++;
    foreach (offs[i]) begin
      bus_xfer(1'b0, offs[i], 32'h0, r1, d1, rn, dn);
      n_total++;
      if (r1 !== 1'b1 || d1 !== 32'h0 || rn !== 1'b0 || dn !== 32'h0)
        $display("FAIL reset_read off=%h ready=%b data=%h next_ready=%b next_data=%h want 1/0/0/0", offs[i], r1, d1, rn, dn);
      else n_pass++;
    end
  endtask

  task automatic test_snapshot();
    logic r1, rn; logic [31:0] d1, dn;
    cnt[0] = 64'h0000_0001_2345_6789;
    cnt[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    cnt[2] = 64'h1111_2222_3333_4444;
    cnt[3] = 64'h5555_6666_7777_8888;
    cnt[4] = 64'h9999_0000_1234_5678;
    cnt[5] = 64'hDEAD_BEEF_CAFE_F00D;
    foreach (exp64[i]) exp64[i] = cnt[i];
    bus_xfer(1'b1, 32'h00, 32'h1, r1, d1, rn, dn);
    n_total++;
    if (r1 !== 1'b1 || rn !== 1'b0 || d1 !== 32'h0) $display("FAIL snap_write_resp ready=%b next=%b data=%h want 1/0/0", r1, rn, d1);
    else n_pass++;
    bus_xfer(1'b0, 32'h08, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== 32'h2345_6789) $display("FAIL snap_iflush_lo got %h want 23456789", d1);
    else n_pass++;
    bus_xfer(1'b0, 32'h0C, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== 32'h0000_0001) $display("FAIL snap_iflush_hi got %h want 00000001", d1);
    else n_pass++;
    bus_xfer(1'b0, 32'h04, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== 32'h1) $display("FAIL snap_seq got %h want 00000001", d1);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic r1, rn; logic [31:0] d1, dn, want;
    foreach (cnt[i]) cnt[i] = ~cnt[i] + 64'd7;
    for (int w = 0; w < 12; w++) begin
      bus_xfer(1'b0, 32'h08 + 32'(4 * w), 32'h0, r1, d1, rn, dn);
      want = w[0] ? exp64[w / 2][63:32] : exp64[w / 2][31:0];
      n_total++;
      if (r1 !== 1'b1 || d1 !== want) $display("FAIL hold_word%0d ready=%b got %h want %h", w, r1, d1, want);
      else n_pass++;
    end
    // Writes outside CTRL are ignored.
    bus_xfer(1'b1, 32'h08, 32'hFFFF_FFFF, r1, d1, rn, dn);
    bus_xfer(1'b0, 32'h08, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== exp64[0][31:0]) $display("FAIL ignored_write got %h want %h", d1, exp64[0][31:0]);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic r1, rn; logic [31:0] d1, dn;
    force dut.r_snap_seq = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_snap_seq;
    bus_xfer(1'b0, 32'h04, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== 32'hFFFF_FFFF) $display("FAIL seq_preload got %h want ffffffff", d1);
    else n_pass++;
    foreach (exp64[i]) exp64[i] = cnt[i];
    bus_xfer(1'b1, 32'h00, 32'h1, r1, d1, rn, dn);
    bus_xfer(1'b0, 32'h04, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== 32'h0) $display("FAIL seq_wrap got %h want 00000000", d1);
    else n_pass++;
    bus_xfer(1'b0, 32'h34, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== exp64[5][63:32]) $display("FAIL wrap_snapshot got %h want %h", d1, exp64[5][63:32]);
    else n_pass++;
    exp_seq = 32'h0;
  endtask

  task automatic test_clear();
    logic r1, rn; logic [31:0] d1, dn;
    foreach (cnt[i]) cnt[i] = 64'h0100_0000_0000_0000 * 64'(i + 1) + 64'h42;
`ifdef PROF_CLR_EN
    foreach (exp64[i]) exp64[i] = cnt[i];
    strobe = 1'b1; rw = 1'b1; addr = 32'h0; wdata = 32'h3;
    @(negedge clk);
    strobe = 1'b0; rw = 1'b0; wdata = '0;
    n_total++;
    if (ready !== 1'b1 || prof_clr !== 1'b0) $display("FAIL clr_t1 ready=%b clr=%b want 1/0", ready, prof_clr);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (prof_clr !== 1'b1) $display("FAIL clr_t2 clr=%b want 1", prof_clr);
    else n_pass++;
    foreach (cnt[i]) cnt[i] = '0;
    @(negedge clk);
    n_total++;
    if (prof_clr !== 1'b0) $display("FAIL clr_t3 clr=%b want 0", prof_clr);
    else n_pass++;
    exp_seq = exp_seq + 1;
`else
    bus_xfer(1'b1, 32'h00, 32'h2, r1, d1, rn, dn);
`endif
    bus_xfer(1'b0, 32'h04, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== exp_seq) $display("FAIL clr_seq got %h want %h", d1, exp_seq);
    else n_pass++;
    bus_xfer(1'b0, 32'h18, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== exp64[2][31:0]) $display("FAIL clr_shadow_lo got %h want %h", d1, exp64[2][31:0]);
    else n_pass++;
    bus_xfer(1'b0, 32'h2C, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (d1 !== exp64[4][63:32]) $display("FAIL clr_shadow_hi got %h want %h", d1, exp64[4][63:32]);
    else n_pass++;
  endtask

  task automatic test_bus_edges();
    logic r1, rn; logic [31:0] d1, dn;
    strobe = 1'b1; rw = 1'b0; addr = 32'h08;
    @(negedge clk);
    n_total++;
    if (ready !== 1'b1) $display("FAIL drop_first ready=%b want 1", ready);
    else n_pass++;
    addr = 32'h04;
    @(negedge clk);
    strobe = 1'b0;
    n_total++;
    if (ready !== 1'b0 || rdata !== 32'h0) $display("FAIL drop_second ready=%b data=%h want 0/0", ready, rdata);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (ready !== 1'b0) $display("FAIL drop_late ready=%b want 0", ready);
    else n_pass++;
    bus_xfer(1'b0, 32'h40, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (r1 !== 1'b1 || d1 !== 32'h0 || rn !== 1'b0) $display("FAIL read_0x40 ready=%b data=%h next=%b want 1/0/0", r1, d1, rn);
    else n_pass++;
    strobe = 1'b1; rw = 1'b0; addr = 32'h0C;
    @(negedge clk);
    strobe = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (ready !== 1'b0 || rdata !== 32'h0) $display("FAIL reset_in_resp ready=%b data=%h want 0/0", ready, rdata);
    else n_pass++;
    bus_xfer(1'b0, 32'h08, 32'h0, r1, d1, rn, dn);
    n_total++;
    if (r1 !== 1'b1 || d1 !== 32'h0) $display("FAIL post_reset_shadow ready=%b data=%h want 1/0", r1, d1);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    foreach (cnt[i]) cnt[i] = '0;
    exp_seq = '0;
    @(negedge clk);
    test_reset();
    test_snapshot();
    test_hold();
    test_wrap();
    test_clear();
    test_bus_edges();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
